// File: rtl/scan_sum_display.sv
// rtl/scan_sum_display.sv - switch adder with registered LED sum and multiplexed digit scanner
// Optional digit blanking at the end of each slot: define SCAN_SUM_BLANK_EN.
module scan_sum_display #(
  parameter int NUM_CH       = 2,
  parameter int W            = 4,
  parameter int SCAN_DIV     = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH*W-1:0]           sw,
  input  logic                          sample,
  output logic [W+$clog2(NUM_CH)-1:0]   leds,
  output logic                          sum_valid,
  output logic [NUM_CH-1:0]             digit_en,
  output logic [3:0]                    digit_val
);

  localparam int SW = W + $clog2(NUM_CH);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_CH);

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic              cnt_wrap;
  logic [SW-1:0]     total;
  logic [W-1:0]      cur_ch;
  logic [NUM_CH-1:0] en_next;

  assign cnt_wrap = (cnt == CW'(SCAN_DIV - 1));

  // Sum is formed at SW bits so NUM_CH full-scale channels can never overflow.
  always_comb begin
    total = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      total = total + SW'(sw[k*W +: W]);
    end
  end

  always_comb begin
    cur_ch = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx == IW'(k)) begin
        cur_ch = sw[k*W +: W];
      end
    end
  end

  always_comb begin
    en_next = ~(NUM_CH'(1) << idx);
`ifdef SCAN_SUM_BLANK_EN
    if (cnt >= CW'(SCAN_DIV - BLANK_CYCLES)) begin
      en_next = '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      idx       <= '0;
      leds      <= '0;
      sum_valid <= 1'b0;
      digit_en  <= '1;
      digit_val <= '0;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + CW'(1);
      if (cnt_wrap) begin
        idx <= (idx == IW'(NUM_CH - 1)) ? '0 : idx + IW'(1);
      end
      // Display outputs are driven from the pre-edge slot state, one cycle behind it.
      digit_en  <= en_next;
      digit_val <= 4'(cur_ch);
      if (sample) begin
        leds      <= total;
        sum_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/scan_sum_display.md
SCAN_SUM_DISPLAY -- requirements
Module: scan_sum_display

Interface
REQ-001 Parameter NUM_CH, default 2, number of switch channels and display digits; legal range 2..4.
REQ-002 Parameter W, default 4, width of each switch channel in bits; legal range 1..4.
REQ-003 Parameter SCAN_DIV, default 4, clock cycles per digit slot; legal range 2..65535.
REQ-004 Parameter BLANK_CYCLES, default 1, blanked cycles at the end of each slot; legal range 1..SCAN_DIV-1.
REQ-005 Local constant SW: SW = W + clog2(NUM_CH).
REQ-006 clk  input  1  Single system clock; all state updates on its rising edge.
REQ-007 reset  input  1  Synchronous, active-high reset.
REQ-008 sw  input  NUM_CH*W  Switch channels, channel k at bits [k*W+W-1 : k*W].
REQ-009 sample  input  1  Sum-capture enable; tie high for continuous update.
REQ-010 leds  output  SW  Registered unsigned sum of all channels.
REQ-011 sum_valid  output  1  High once at least one sum has been captured since reset.
REQ-012 digit_en  output  NUM_CH  Active-low one-hot digit (anode) enable.
REQ-013 digit_val  output  4  Zero-extended value of the channel currently displayed.

Function
REQ-014 Internal slot counter cnt SHALL count 0..SCAN_DIV-1 and wrap to 0.
REQ-015 Internal digit index idx SHALL advance by 1 when cnt wraps, with NUM_CH-1 -> 0 wrap-around.
REQ-016 On each non-reset edge, digit_en SHALL load ~(1<<idx) and digit_val SHALL load channel idx, both from pre-edge idx and cnt; outputs lag the state by one cycle.
REQ-017 After reset release, edges 1..SCAN_DIV SHALL show digit 0, edges SCAN_DIV+1..2*SCAN_DIV SHALL show digit 1, and so on cyclically.
REQ-018 digit_en SHALL never have more than one bit low.
REQ-019 digit_val SHALL track switch changes within a slot, with one-cycle latency.
REQ-020 On an edge with sample=1, leds SHALL load the sum of all NUM_CH channels, computed at SW bits with no overflow possible; latency is 1 cycle.
REQ-021 On an edge with sample=0, leds SHALL hold its value.
REQ-022 sum_valid SHALL rise on the first sample edge after reset and stay high until the next reset.
REQ-023 Sum capture and scanning SHALL be independent; sample SHALL NOT perturb cnt or idx.

Reset
REQ-024 reset=1 at an edge SHALL set cnt=0, idx=0, leds=0, sum_valid=0, digit_en=all ones, and digit_val=0.
REQ-025 Reset asserted mid-slot or mid-sample SHALL take priority over all other updates; scanning restarts at digit 0 per REQ-017.
REQ-026 Reset held for several cycles SHALL keep all outputs at their reset values.

Configuration
REQ-027 Macro SCAN_SUM_BLANK_EN: when defined, digit_en SHALL load all ones on any edge where pre-edge cnt >= SCAN_DIV-BLANK_CYCLES.
REQ-028 With SCAN_SUM_BLANK_EN defined, digit_val SHALL still load channel idx during blanked cycles.
REQ-029 Without SCAN_SUM_BLANK_EN, no blanking SHALL occur, BLANK_CYCLES SHALL be ignored, and REQ-017 SHALL apply unmodified.

Verification
REQ-030 Scan: NUM_CH=2, SCAN_DIV=4, no macro; release reset -> digit_en=2'b10 on edges 1-4, 2'b01 on edges 5-8, 2'b10 on edge 9.
REQ-031 Sum: NUM_CH=2, W=4; sw={4'hF,4'hF}, one-cycle sample pulse -> leds=5'b11110 and sum_valid=1 on the next edge; then change sw to {4'h1,4'h2} with sample=0 -> leds stays 5'b11110.
REQ-032 Width: NUM_CH=4, W=4; all channels 4'hF with sample=1 -> leds=6'd60; all channels 0 -> leds=0 next edge.
REQ-033 Reset mid-operation: assert reset on edge 6 of the REQ-030 configuration -> digit_en=2'b11 and leds=0 while reset is held; after release, edges 1-4 show digit_en=2'b10.
REQ-034 Blanking: SCAN_SUM_BLANK_EN defined, SCAN_DIV=4, BLANK_CYCLES=1 -> digit_en=10,10,10,11,01,01,01,11 on edges 1-8.
REQ-035 Digit value: sw={4'h3,4'hA} -> digit_val=4'hA while digit_en=2'b10, and 4'h3 while digit_en=2'b01.
